// File: rtl/dpc_bp_list_merger_if.sv
// Table write port between the list merger and the DPC corrector.
// master drives wen/waddr/wdata; slave is the corrector table side.
interface dpc_bp_list_merger_if #(
    parameter int ALL_BP_BIT = 9
);
    logic                  all_bp_wen;
    logic [ALL_BP_BIT-1:0] all_bp_waddr;
    logic [31:0]           all_bp_wdata;

    modport master (
        output all_bp_wen,
        output all_bp_waddr,
        output all_bp_wdata
    );

    modport slave (
        input all_bp_wen,
        input all_bp_waddr,
        input all_bp_wdata
    );
endinterface

// File: rtl/dpc_bp_list_merger.sv
// Merges manual and auto bad-pixel lists into one ascending, de-duplicated table.
// Ports: aclk/rst, start, man_*/auto_* list reads, wr table port, status outputs.
module dpc_bp_list_merger #(
    parameter int ALL_BP_NUM  = 512,
    parameter int ALL_BP_BIT  = 9,
    parameter int MAN_BP_BIT  = 8,
    parameter int AUTO_BP_BIT = 9
) (
    input  logic                   aclk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [MAN_BP_BIT:0]    man_num,
    output logic [MAN_BP_BIT-1:0]  man_raddr,
    input  logic [31:0]            man_rdata,
    input  logic [AUTO_BP_BIT:0]   auto_num,
    output logic [AUTO_BP_BIT-1:0] auto_raddr,
    input  logic [31:0]            auto_rdata,
    dpc_bp_list_merger_if.master   wr,
    output logic [ALL_BP_BIT:0]    all_bp_num,
    output logic                   bp_table_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WT   = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [ALL_BP_BIT:0] CAP =
        (ALL_BP_BIT+1)'(ALL_BP_NUM);
    localparam logic [MAN_BP_BIT:0] MAN_CAP =
        {1'b1, {MAN_BP_BIT{1'b0}}};
    localparam logic [AUTO_BP_BIT:0] AUTO_CAP =
        {1'b1, {AUTO_BP_BIT{1'b0}}};

    logic [2:0]             state;
    logic [MAN_BP_BIT:0]    man_cnt;
    logic [AUTO_BP_BIT:0]   auto_cnt;
    logic [MAN_BP_BIT:0]    im;
    logic [AUTO_BP_BIT:0]   ia;
    logic [ALL_BP_BIT:0]    wcnt;
    logic [31:0]            man_head;
    logic [31:0]            auto_head;
    logic [31:0]            last_key;
    logic                   last_vld;

    logic                   man_end;
    logic                   auto_end;
    logic [32:0]            km;
    logic [32:0]            ka;
    logic                   sel_m;
    logic                   sel_a;
    logic [31:0]            sel_key;
    logic [31:0]            sel_data;
    logic                   dup;

    assign man_raddr  = im[MAN_BP_BIT-1:0];
    assign auto_raddr = ia[AUTO_BP_BIT-1:0];

    assign man_end  = (im >= man_cnt);
    assign auto_end = (ia >= auto_cnt);

    // Key is {y, x}; the top bit makes an exhausted head compare as +inf.
    assign km = {man_end, man_head[15:0], man_head[31:16]};
    assign ka = {auto_end, auto_head[15:0], auto_head[31:16]};

    // Equal keys select both, so both indices advance on one write.
    assign sel_m    = (km <= ka);
    assign sel_a    = (ka <= km);
    assign sel_key  = sel_m ? km[31:0] : ka[31:0];
    assign sel_data = sel_m ? man_head : auto_head;
    assign dup      = last_vld && (last_key == sel_key);

    always_ff @(posedge aclk) begin
        if (rst) begin
            state           <= S_IDLE;
            man_cnt         <= '0;
            auto_cnt        <= '0;
            im              <= '0;
            ia              <= '0;
            wcnt            <= '0;
            man_head        <= '0;
            auto_head       <= '0;
            last_key        <= '0;
            last_vld        <= 1'b0;
            wr.all_bp_wen   <= 1'b0;
            wr.all_bp_waddr <= '0;
            wr.all_bp_wdata <= '0;
            all_bp_num      <= '0;
            bp_table_ready  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            wr.all_bp_wen <= 1'b0;
            done          <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        man_cnt <= (man_num > MAN_CAP) ?
                                   MAN_CAP : man_num;
                        auto_cnt <= (auto_num > AUTO_CAP) ?
                                    AUTO_CAP : auto_num;
                        im             <= '0;
                        ia             <= '0;
                        wcnt           <= '0;
                        overflow       <= 1'b0;
                        last_vld       <= 1'b0;
                        bp_table_ready <= 1'b0;
                        busy           <= 1'b1;
                        state          <= S_RD;
                    end
                end
                S_RD: begin
                    if (man_end && auto_end) begin
                        state <= S_FIN;
                    end else if (wcnt == CAP) begin
                        overflow <= 1'b1;
                        state    <= S_FIN;
                    end else begin
                        state <= S_WT;
                    end
                end
                S_WT: begin
                    man_head  <= man_rdata;
                    auto_head <= auto_rdata;
                    state     <= S_CMP;
                end
                S_CMP: begin
                    if (sel_m) im <= im + 1'b1;
                    if (sel_a) ia <= ia + 1'b1;
                    if (!dup) begin
                        wr.all_bp_wen   <= 1'b1;
                        wr.all_bp_waddr <= wcnt[ALL_BP_BIT-1:0];
                        wr.all_bp_wdata <= sel_data;
                        wcnt            <= wcnt + 1'b1;
                        last_key        <= sel_key;
                        last_vld        <= 1'b1;
                    end
                    state <= S_RD;
                end
                S_FIN: begin
                    all_bp_num     <= wcnt;
                    bp_table_ready <= 1'b1;
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/dpc_bp_list_merger.md
# dpc_bp_list_merger

Builds the combined bad-pixel table consumed by the DPC corrector. It merge-sorts the manual bad-pixel list and the auto-detected list, both held in raster order, into one strictly ascending, de-duplicated list. The result is written through the corrector's table write port (`all_bp_*`). `bp_table_ready` is held low for the whole rebuild, so the corrector never performs lookups on a half-written table.

## Interface
Parameters:
- `ALL_BP_NUM`, 512, capacity of the combined table
- `ALL_BP_BIT`, 9, combined table address width
- `MAN_BP_BIT`, 8, manual list address width
- `AUTO_BP_BIT`, 9, auto list address width

Ports:
- `aclk`  in  1  clock; the same clock drives the corrector's table write port (`S_AXI_ACLK`)
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  single-cycle request to rebuild the table
- `man_num`  in  `MAN_BP_BIT+1`  manual entry count, sampled on `start`
- `man_raddr`  out  `MAN_BP_BIT`  manual list read address
- `man_rdata`  in  32  manual entry: x in [31:16], y in [15:0]; valid 1 cycle after address
- `auto_num`  in  `AUTO_BP_BIT+1`  auto entry count, sampled on `start`
- `auto_raddr`  out  `AUTO_BP_BIT`  auto list read address
- `auto_rdata`  in  32  auto entry, same format and latency as `man_rdata`
- `all_bp_wen`  out  1  table write strobe
- `all_bp_waddr`  out  `ALL_BP_BIT`  table write address
- `all_bp_wdata`  out  32  table write data, same format as the source lists
- `all_bp_num`  out  `ALL_BP_BIT+1`  number of valid table entries
- `bp_table_ready`  out  1  table is valid
- `busy`  out  1  merge in progress
- `done`  out  1  one-cycle pulse when the merge completes
- `overflow`  out  1  sticky; set when the table was truncated, cleared on `start`

## Operation
- Sort key = {y[15:0], x[15:0]}, compared unsigned, so y is major. An exhausted list's head counts as +infinity.
- `start` in IDLE: latch `man_num` and `auto_num`, clear both indices and `wcnt`, clear `overflow`, clear last-written-valid, drop `bp_table_ready`, go to RD.
- `start` outside IDLE is ignored.
- States and transitions:
  - **IDLE**: waits for `start`.
  - **RD**: drive `man_raddr`=`im` and `auto_raddr`=`ia`.
    - Both lists exhausted → FIN.
    - Else `wcnt`==`ALL_BP_NUM` → set `overflow`, go to FIN.
    - Else → WT.
  - **WT**: register both rdata heads.
  - **CMP**: select the smaller key.
    - If keys are equal, take one copy and advance both indices.
    - Otherwise advance only the selected list's index.
    - If the selected key equals the last written key (duplicate within one list), advance the index but do not write.
    - Else issue the write: `all_bp_waddr`=`wcnt`, `wcnt`++, update the last written key.
    - Go to RD.
  - **FIN**: `all_bp_num`<=`wcnt`, `bp_table_ready`<=1, `done`<=1, go to IDLE.
- Overflow is conservative: it is set whenever entries remain at full capacity, even if every remaining entry would have been a duplicate.
- `busy` = (state != IDLE).

## Timing
- Every output is registered. Reset values: all outputs 0, state IDLE.
- Write strobe: `all_bp_wen`, `all_bp_waddr` and `all_bp_wdata` are registered in CMP and visible for exactly 1 cycle, in the following RD cycle.
- Cycle numbering takes the `start` edge as cycle 0, with N = number of CMP iterations.
  - `busy` is high from cycle 1.
  - Iteration i occupies cycles 3i+1 (RD), 3i+2 (WT) and 3i+3 (CMP).
  - The final RD is at 3N+1, FIN at 3N+2.
  - `done`, `bp_table_ready` and the new `all_bp_num` are visible at cycle 3N+3; `busy` is low from 3N+3.
- Empty lists: N=0, so `done` appears at cycle 3 with `all_bp_num`=0 and `bp_table_ready`=1.
- `bp_table_ready` goes low in cycle 1 after `start` and stays low until FIN.
- `all_bp_num` holds its previous value until FIN.
- Reset mid-merge: immediate return to IDLE with all outputs 0. The table contents are treated as invalid because `bp_table_ready`=0.
- Count inputs latched above the source capacity (`man_num` > 2^`MAN_BP_BIT`, `auto_num` > 2^`AUTO_BP_BIT`) are clamped to that capacity.

## Test plan
- **Basic merge.** Manual {(5,2),(10,3)}, auto {(7,2),(10,3),(1,4)}.
  - Writes 0x00050002, 0x00070002, 0x000A0003, 0x00010004 to addresses 0-3.
  - `all_bp_num`=4, `done` at cycle 15, `overflow`=0.
- **Empty lists.** `man_num`=`auto_num`=0.
  - No `all_bp_wen` pulse.
  - `done` and `bp_table_ready` at cycle 3, `all_bp_num`=0.
- **Overflow.** `ALL_BP_NUM`=4, manual holds 3 distinct entries, auto holds 3 distinct entries, all 6 unique.
  - Exactly 4 writes, holding the 4 smallest keys.
  - `overflow`=1 and `all_bp_num`=4 at `done`.
- **In-list duplicates and one-sided input.** Manual {(3,1),(3,1),(9,1)}, auto empty.
  - 2 writes: 0x00030001, 0x00090001.
  - `all_bp_num`=2, `done` at cycle 12.
- **Start while busy, then reset mid-merge.**
  - A second `start` at cycle 5 is ignored; the timing is unchanged.
  - Asserting `rst` at cycle 7 of a later merge forces `busy`=0, `bp_table_ready`=0 and `all_bp_num`=0 on the next cycle.
- **Rebuild after ready.** Run a second `start` after a completed merge.
  - `bp_table_ready` falls at cycle 1.
  - The old `all_bp_num` is held until the new `done`.
